axil_ram_slave: RTL and testbench

AXI4-Lite slave memory that terminates the AXI-Lite master port of the AXI-to-AXI-Lite bridge. It accepts single-beat writes with byte strobes and single-beat reads, and stores them in a word-addressed array. Accesses outside the configured window get an SLVERR response. It is the default downstream target in bridge benches and the system-level integration model.

---
 rtl/axil_pkg.sv | 17 +
 rtl/axil_ram_core.sv | 32 +++
 rtl/axil_ram_slave.sv | 129 ++++++++++++
 tb/tb_axil_ram_slave.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the RAM slave and the bridge bench.
package axil_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  function automatic int unsigned win_bytes(input int unsigned strb_w, input int unsigned words_log2);
    return strb_w << words_log2;
  endfunction

endpackage

// File: rtl/axil_ram_core.sv
// Byte-enabled word array with one write port and one synchronous read-first read port.
module axil_ram_core
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 10
) (
  input  logic                      clk,
  input  logic                      wr_en_i,
  input  logic [MEM_WORDS_LOG2-1:0] wr_idx_i,
  input  logic [DATA_WIDTH-1:0]     wr_data_i,
  input  logic [DATA_WIDTH/8-1:0]   wr_strb_i,
  input  logic                      rd_en_i,
  input  logic [MEM_WORDS_LOG2-1:0] rd_idx_i,
  output logic [DATA_WIDTH-1:0]     rd_data_o
);

  localparam int unsigned STRB_W = strb_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [0:(1 << MEM_WORDS_LOG2)-1];

  // Non-blocking read of the same word being written returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wr_strb_i[b]) mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
    if (rd_en_i) rd_data_o <= mem_q[rd_idx_i];
  end

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave RAM: AW/W holding registers, range-checked commit, registered B and R responses.
module axil_ram_slave
  import axil_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned           MEM_WORDS_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int unsigned           OFF_BITS = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH:0]   WIN_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   WIN_HI   =
    WIN_LO + (ADDR_WIDTH+1)'(win_bytes(STRB_WIDTH, MEM_WORDS_LOG2));

  logic                      aw_full_q, w_full_q;
  logic [ADDR_WIDTH-1:0]     awaddr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [STRB_WIDTH-1:0]     wstrb_q;
  logic                      bvalid_q, rvalid_q, rok_q;
  resp_t                     bresp_q, rresp_q;
  logic                      aw_hs, w_hs, ar_hs, commit;
  logic                      aw_in_range, ar_in_range;
  logic [ADDR_WIDTH-1:0]     aw_rel, ar_rel;
  logic [DATA_WIDTH-1:0]     core_rdata;
  logic                      unused_ok;

  assign aw_hs  = s_axil_awvalid && !aw_full_q;
  assign w_hs   = s_axil_wvalid && !w_full_q;
  assign ar_hs  = s_axil_arvalid && (!rvalid_q || s_axil_rready);
  assign commit = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);

  assign aw_in_range = ({1'b0, awaddr_q} >= WIN_LO) && ({1'b0, awaddr_q} < WIN_HI);
  assign ar_in_range = ({1'b0, s_axil_araddr} >= WIN_LO) && ({1'b0, s_axil_araddr} < WIN_HI);
  assign aw_rel      = awaddr_q - BASE_ADDR;
  assign ar_rel      = s_axil_araddr - BASE_ADDR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full_q <= 1'b0;
      awaddr_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rok_q     <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_full_q <= 1'b1;
        awaddr_q  <= s_axil_awaddr;
      end else if (commit) begin
        aw_full_q <= 1'b0;
      end
      if (w_hs) begin
        w_full_q <= 1'b1;
        wdata_q  <= s_axil_wdata;
        wstrb_q  <= s_axil_wstrb;
      end else if (commit) begin
        w_full_q <= 1'b0;
      end
      if (commit) begin
        bvalid_q <= 1'b1;
        bresp_q  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil_bready) begin
        bvalid_q <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        rok_q    <= ar_in_range;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  axil_ram_core #(
    .DATA_WIDTH     (DATA_WIDTH),
    .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
  ) u_core (
    .clk       (clk),
    .wr_en_i   (commit && aw_in_range),
    .wr_idx_i  (aw_rel[OFF_BITS +: MEM_WORDS_LOG2]),
    .wr_data_i (wdata_q),
    .wr_strb_i (wstrb_q),
    .rd_en_i   (ar_hs && ar_in_range),
    .rd_idx_i  (ar_rel[OFF_BITS +: MEM_WORDS_LOG2]),
    .rd_data_o (core_rdata)
  );

  // The array output is unreset, so out-of-range and post-reset reads are forced to zero here.
  assign s_axil_rdata   = rok_q ? core_rdata : '0;
  assign s_axil_rresp   = rresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_arready = !rvalid_q || s_axil_rready;
  assign s_axil_awready = !aw_full_q;
  assign s_axil_wready  = !w_full_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_bvalid  = bvalid_q;

  assign unused_ok = ^{s_axil_awprot, s_axil_arprot, aw_rel, ar_rel};

endmodule

// File: tb/tb_axil_ram_slave.sv
// Bench for axil_ram_slave: directed vector table, hand-built corner sequences, randomized traffic vs. a word-array model.
module tb_axil_ram_slave;

  localparam logic [31:0] BASE = 32'h0;
  localparam longint      WIN  = 4 * 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axil_awaddr, s_axil_wdata, s_axil_araddr, s_axil_rdata;
  logic [2:0]  s_axil_awprot, s_axil_arprot;
  logic [3:0]  s_axil_wstrb;
  logic [1:0]  s_axil_bresp, s_axil_rresp;
  logic        s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
  logic        s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
  logic        s_axil_rvalid, s_axil_rready;

  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [0:1023];

  always #5 clk = ~clk;

  axil_ram_slave #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .STRB_WIDTH     (4),
    .MEM_WORDS_LOG2 (10),
    .BASE_ADDR      (BASE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready)
  );

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;      // >0: W offered this many cycles before AW; <0: AW first
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + WIN);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int lead, output logic [1:0] resp, output int lat);
    bit aw_done = 0, w_done = 0, ahs, whs;
    int c = 0, n = 0;
    s_axil_awaddr = addr;
    s_axil_wdata  = data;
    s_axil_wstrb  = strb;
    s_axil_bready = 1'b1;
    while (!(aw_done && w_done) && c < 50) begin
      s_axil_awvalid = !aw_done && (c >= (lead > 0 ? lead : 0));
      s_axil_wvalid  = !w_done && (c >= (lead < 0 ? -lead : 0));
      #0;
      ahs = s_axil_awvalid && s_axil_awready;
      whs = s_axil_wvalid && s_axil_wready;
      tick();
      aw_done |= ahs;
      w_done  |= whs;
      c++;
    end
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    while (!s_axil_bvalid && n < 50) begin
      tick();
      n++;
    end
    lat  = c + n;
    resp = s_axil_bresp;
    if (in_rng(addr))
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[widx(addr)][b*8 +: 8] = data[b*8 +: 8];
    tick();
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit hs = 0;
    int c = 0, n = 0;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b1;
    while (!hs && c < 50) begin
      #0;
      hs = s_axil_arready;
      tick();
      c++;
    end
    s_axil_arvalid = 1'b0;
    while (!s_axil_rvalid && n < 50) begin
      tick();
      n++;
    end
    lat  = c + n;
    data = s_axil_rdata;
    resp = s_axil_rresp;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 99);
    if (r < 70) return 32'($urandom_range(0, 31) * 4 + $urandom_range(0, 3));
    if (r < 85) return 32'((1020 + $urandom_range(0, 3)) * 4 + $urandom_range(0, 3));
    if (r < 95) return 32'h1000 + 32'($urandom_range(0, 63) * 4);
    return $urandom() | 32'h1000_0000;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  rsp;
    int          lat;

    vt[0]  = '{1, 32'h10,       32'hDEADBEEF, 4'hF,  0, 32'h0,        2'b00};
    vt[1]  = '{0, 32'h10,       32'h0,        4'h0,  0, 32'hDEADBEEF, 2'b00};
    vt[2]  = '{1, 32'h10,       32'h0000CAFE, 4'h3,  3, 32'h0,        2'b00};
    vt[3]  = '{0, 32'h10,       32'h0,        4'h0,  0, 32'hDEADCAFE, 2'b00};
    vt[4]  = '{1, 32'h0,        32'h11111111, 4'hF, -1, 32'h0,        2'b00};
    vt[5]  = '{1, 32'h4,        32'h22222222, 4'hF,  0, 32'h0,        2'b00};
    vt[6]  = '{1, 32'h8,        32'h33333333, 4'hF,  2, 32'h0,        2'b00};
    vt[7]  = '{1, 32'h1000,     32'hAAAAAAAA, 4'hF,  0, 32'h0,        2'b10};
    vt[8]  = '{0, 32'h0,        32'h0,        4'h0,  0, 32'h11111111, 2'b00};
    vt[9]  = '{0, 32'h1000,     32'h0,        4'h0,  0, 32'h0,        2'b10};
    vt[10] = '{0, 32'h13,       32'h0,        4'h0,  0, 32'hDEADCAFE, 2'b00};
    vt[11] = '{1, 32'hFFF,      32'h12345678, 4'hF, -2, 32'h0,        2'b00};
    vt[12] = '{0, 32'hFFC,      32'h0,        4'h0,  0, 32'h12345678, 2'b00};
    vt[13] = '{1, 32'h6,        32'h00AB0000, 4'h4,  1, 32'h0,        2'b00};
    vt[14] = '{0, 32'h4,        32'h0,        4'h0,  0, 32'h22AB2222, 2'b00};
    vt[15] = '{0, 32'hFFFFFFFC, 32'h0,        4'h0,  0, 32'h0,        2'b10};
    vt[16] = '{1, 32'h30,       32'h01234567, 4'hF,  0, 32'h0,        2'b00};

    rst = 1'b0;
    s_axil_awaddr = '0; s_axil_awprot = 3'b0; s_axil_awvalid = 1'b0;
    s_axil_wdata = '0; s_axil_wstrb = '0; s_axil_wvalid = 1'b0; s_axil_bready = 1'b1;
    s_axil_araddr = '0; s_axil_arprot = 3'b0; s_axil_arvalid = 1'b0; s_axil_rready = 1'b1;
    tick();
    tick();
    chk("rst awready", s_axil_awready, 1);
    chk("rst wready",  s_axil_wready,  1);
    chk("rst arready", s_axil_arready, 1);
    chk("rst bvalid",  s_axil_bvalid,  0);
    chk("rst bresp",   s_axil_bresp,   0);
    chk("rst rvalid",  s_axil_rvalid,  0);
    chk("rst rresp",   s_axil_rresp,   0);
    chk("rst rdata",   s_axil_rdata,   0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      if (vt[i].is_wr) begin
        axi_write(vt[i].addr, vt[i].data, vt[i].strb, vt[i].lead, rsp, lat);
        chk($sformatf("v%0d bresp", i), rsp, vt[i].exp_resp);
        chk($sformatf("v%0d wlat", i), lat, (vt[i].lead < 0 ? -vt[i].lead : vt[i].lead) + 2);
      end else begin
        axi_read(vt[i].addr, d, rsp, lat);
        chk($sformatf("v%0d rdata", i), d, vt[i].exp_data);
        chk($sformatf("v%0d rresp", i), rsp, vt[i].exp_resp);
        chk($sformatf("v%0d rlat", i), lat, 1);
      end
    end

    // B backpressure: a pending second write must not commit while bready is low.
    s_axil_bready = 1'b0;
    s_axil_awaddr = 32'h1000; s_axil_wdata = 32'hFFFFFFFF; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    tick();
    chk("bp b1 bvalid", s_axil_bvalid, 1);
    chk("bp b1 bresp",  s_axil_bresp,  2'b10);
    s_axil_awaddr = 32'h20; s_axil_wdata = 32'h5A5A5A5A;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    #0;
    chk("bp awready before", s_axil_awready, 1);
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d awready", k), s_axil_awready, 0);
      chk($sformatf("bp%0d wready", k),  s_axil_wready,  0);
      chk($sformatf("bp%0d bvalid", k),  s_axil_bvalid,  1);
      chk($sformatf("bp%0d bresp", k),   s_axil_bresp,   2'b10);
      tick();
    end
    s_axil_bready = 1'b1;
    tick();
    chk("bp b2 bvalid", s_axil_bvalid, 1);
    chk("bp b2 bresp",  s_axil_bresp,  2'b00);
    tick();
    chk("bp b2 done", s_axil_bvalid, 0);
    mdl[8] = 32'h5A5A5A5A;
    axi_read(32'h20, d, rsp, lat);
    chk("bp readback", d, 32'h5A5A5A5A);

    // Back-to-back reads, then R backpressure.
    s_axil_rready = 1'b1;
    s_axil_araddr = 32'h0; s_axil_arvalid = 1'b1;
    tick();
    chk("b2b0 rvalid", s_axil_rvalid, 1);
    chk("b2b0 rdata",  s_axil_rdata,  32'h11111111);
    s_axil_araddr = 32'h4;
    tick();
    chk("b2b1 rvalid", s_axil_rvalid, 1);
    chk("b2b1 rdata",  s_axil_rdata,  32'h22AB2222);
    s_axil_araddr = 32'h8;
    tick();
    chk("b2b2 rvalid", s_axil_rvalid, 1);
    chk("b2b2 rdata",  s_axil_rdata,  32'h33333333);
    s_axil_rready = 1'b0;
    s_axil_araddr = 32'h10;
    #1;
    chk("rbp arready", s_axil_arready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rbp%0d rvalid", k),  s_axil_rvalid,  1);
      chk($sformatf("rbp%0d rdata", k),   s_axil_rdata,   32'h33333333);
      chk($sformatf("rbp%0d arready", k), s_axil_arready, 0);
    end
    s_axil_rready = 1'b1;
    #1;
    chk("rbp release arready", s_axil_arready, 1);
    tick();
    chk("rbp next rdata", s_axil_rdata, 32'hDEADCAFE);
    s_axil_arvalid = 1'b0;
    tick();
    chk("rbp drain rvalid", s_axil_rvalid, 0);

    // Commit and read of the same word at one edge returns the old contents.
    s_axil_awaddr = 32'h30; s_axil_wdata = 32'h89ABCDEF; s_axil_wstrb = 4'hF;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 32'h30; s_axil_arvalid = 1'b1;
    tick();
    chk("rf old rdata", s_axil_rdata, 32'h01234567);
    chk("rf bvalid",    s_axil_bvalid, 1);
    s_axil_arvalid = 1'b0;
    tick();
    mdl[12] = 32'h89ABCDEF;
    axi_read(32'h30, d, rsp, lat);
    chk("rf new rdata", d, 32'h89ABCDEF);

    // Asynchronous reset with both responses pending.
    s_axil_bready = 1'b0; s_axil_rready = 1'b0;
    s_axil_awaddr = 32'h34; s_axil_wdata = 32'h0BADF00D;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    tick();
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    s_axil_araddr = 32'h10; s_axil_arvalid = 1'b1;
    tick();
    s_axil_arvalid = 1'b0;
    chk("pre-rst bvalid", s_axil_bvalid, 1);
    chk("pre-rst rvalid", s_axil_rvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst bvalid", s_axil_bvalid, 0);
    chk("arst rvalid", s_axil_rvalid, 0);
    chk("arst rdata",  s_axil_rdata,  0);
    tick();
    rst = 1'b1;
    s_axil_bready = 1'b1; s_axil_rready = 1'b1;
    #1;
    chk("post-rst awready", s_axil_awready, 1);
    chk("post-rst wready",  s_axil_wready,  1);
    chk("post-rst arready", s_axil_arready, 1);
    tick();
    mdl[13] = 32'h0BADF00D;
    axi_read(32'h10, d, rsp, lat);
    chk("post-rst keep 0x10", d, 32'hDEADCAFE);
    axi_read(32'h30, d, rsp, lat);
    chk("post-rst keep 0x30", d, 32'h89ABCDEF);

    // Randomized traffic over a fully initialised subset of the array.
    for (int w = 0; w < 36; w++) begin
      int idx = (w < 32) ? w : 988 + w;
      axi_write(32'(idx * 4), $urandom(), 4'hF, 0, rsp, lat);
    end
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a = rand_addr();
      if ($urandom_range(0, 1) == 1) begin
        int ld = int'($urandom_range(0, 4)) - 2;
        axi_write(a, $urandom(), 4'($urandom_range(0, 15)), ld, rsp, lat);
        chk($sformatf("rnd%0d bresp a=%0h", t, a), rsp, in_rng(a) ? 2'b00 : 2'b10);
        chk($sformatf("rnd%0d wlat", t), lat, (ld < 0 ? -ld : ld) + 2);
      end else begin
        axi_read(a, d, rsp, lat);
        chk($sformatf("rnd%0d rdata a=%0h", t, a), d, in_rng(a) ? mdl[widx(a)] : 32'h0);
        chk($sformatf("rnd%0d rresp", t), rsp, in_rng(a) ? 2'b00 : 2'b10);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
